// File: rtl/hpm_counter_unit_pkg.sv
// Shared definitions for the hardware performance-monitor unit:
// CSR addresses, selector layout, privilege and event IDs.
package hpm_counter_unit_pkg;

  localparam logic [11:0] CSR_MHPM_COUNTER_3 = 12'hB03;
  localparam logic [11:0] CSR_MHPM_EVENT_3   = 12'h323;
  localparam logic [11:0] CSR_MCOUNTINHIBIT  = 12'h320;

  localparam logic [1:0] PRIV_LVL_U = 2'b00;
  localparam logic [1:0] PRIV_LVL_S = 2'b01;
  localparam logic [1:0] PRIV_LVL_M = 2'b11;

  localparam int unsigned EV_NONE       = 0;
  localparam int unsigned EV_L1I_MISS   = 1;
  localparam int unsigned EV_L1D_MISS   = 2;
  localparam int unsigned EV_ITLB_MISS  = 3;
  localparam int unsigned EV_DTLB_MISS  = 4;
  localparam int unsigned EV_LOAD       = 5;
  localparam int unsigned EV_STORE      = 6;
  localparam int unsigned EV_BRANCH     = 7;

  localparam int unsigned MaxSelW = 8;

  typedef struct packed {
    logic               of;
    logic               minh;
    logic               sinh;
    logic               uinh;
    logic [51:0]        rsvd;
    logic [MaxSelW-1:0] sel;
  } hpm_event_t;

  // inh is {minh, sinh, uinh}
  function automatic logic priv_inhibit(
    input logic [2:0] inh,
    input logic [1:0] priv
  );
    logic r;
    r = 1'b0;
    unique case (priv)
      PRIV_LVL_M: r = inh[2];
      PRIV_LVL_S: r = inh[1];
      PRIV_LVL_U: r = inh[0];
      default:    r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hpm_counter_unit_counter.sv
// One programmable counter with its selector and sticky overflow bit.
// A counter write drops that cycle's increment; a wrap beats an OF clear.
module hpm_counter
  import hpm_counter_unit_pkg::*;
#(
  parameter int unsigned CounterWidth = 64,
  parameter int unsigned EvCntW       = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    inc_en,
  input  logic [EvCntW-1:0]       inc,
  input  logic                    cnt_we,
  input  logic                    evt_we,
  input  logic [CounterWidth-1:0] cnt_wdata,
  input  hpm_event_t              evt_wdata,
  output logic [CounterWidth-1:0] cnt,
  output hpm_event_t              evt
);

  logic [CounterWidth:0] sum;
  logic                  wrap;

  assign sum  = {1'b0, cnt} + (CounterWidth+1)'(inc);
  assign wrap = inc_en & sum[CounterWidth] & ~cnt_we;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
      evt <= '0;
    end else begin
      if (cnt_we) begin
        cnt <= cnt_wdata;
      end else if (inc_en) begin
        cnt <= sum[CounterWidth-1:0];
      end
      if (evt_we) begin
        evt <= evt_wdata;
      end
      if (wrap) begin
        evt.of <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hpm_counter_unit.sv
// Programmable HPM counters, mcountinhibit, CSR decode/read mux
// and the local counter-overflow interrupt.
module hpm_counter_unit
  import hpm_counter_unit_pkg::*;
#(
  parameter int unsigned NrCounters    = 6,
  parameter int unsigned NrEvents      = 16,
  parameter int unsigned CounterWidth  = 64,
  parameter int unsigned NrCommitPorts = 2,
  localparam int unsigned EvCntW = $clog2(NrCommitPorts+1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [1:0]                 priv_lvl_i,
  input  logic [NrEvents*EvCntW-1:0] event_cnt_i,
  input  logic [11:0]                csr_addr_i,
  input  logic                       csr_we_i,
  input  logic [63:0]                csr_wdata_i,
  output logic [63:0]                csr_rdata_o,
  output logic                       csr_hit_o,
  output logic                       lcof_irq_o
);

  localparam int unsigned SelW =
    (NrEvents > 1) ? $clog2(NrEvents) : 1;
  localparam logic [31:0] InhMask =
    32'(((64'd1 << NrCounters) - 64'd1) << 3);

  logic [EvCntW-1:0]       ev [NrEvents];
  logic [CounterWidth-1:0] cnt [NrCounters];
  hpm_event_t              evt [NrCounters];
  logic [EvCntW-1:0]       inc [NrCounters];
  logic [NrCounters-1:0]   inc_en;
  logic [NrCounters-1:0]   cnt_we;
  logic [NrCounters-1:0]   evt_we;
  logic [NrCounters-1:0]   of_vec;
  logic [31:0]             mcountinhibit;
  logic                    irq_q;
  hpm_event_t              evt_wdata;
  logic [4:0]              idx;
  logic                    cnt_rng;
  logic                    evt_rng;
  logic                    inh_hit;
  logic                    unused_wdata;

  always_comb begin
    for (int k = 0; k < int'(NrEvents); k++) begin
      ev[k] = event_cnt_i[k*EvCntW +: EvCntW];
    end
  end

  assign idx     = csr_addr_i[4:0];
  assign cnt_rng = (csr_addr_i[11:5] == CSR_MHPM_COUNTER_3[11:5])
                 && (idx >= 5'd3);
  assign evt_rng = (csr_addr_i[11:5] == CSR_MHPM_EVENT_3[11:5])
                 && (idx >= 5'd3);
  assign inh_hit = (csr_addr_i == CSR_MCOUNTINHIBIT);
  assign csr_hit_o = cnt_rng | evt_rng | inh_hit;

  // Reserved selector bits and unused select bits are dropped here
  always_comb begin
    evt_wdata      = '0;
    evt_wdata.of   = csr_wdata_i[63];
    evt_wdata.minh = csr_wdata_i[62];
    evt_wdata.sinh = csr_wdata_i[61];
    evt_wdata.uinh = csr_wdata_i[60];
    evt_wdata.sel[SelW-1:0] = csr_wdata_i[SelW-1:0];
  end

  assign unused_wdata = ^csr_wdata_i[59:SelW];

  for (genvar g = 0; g < NrCounters; g++) begin : g_cnt
    logic [SelW-1:0] sel;
    assign sel       = evt[g].sel[SelW-1:0];
    assign inc[g]    = ev[sel];
    assign inc_en[g] = (sel != '0)
                     && (32'(sel) < NrEvents)
                     && !mcountinhibit[g+3]
                     && !priv_inhibit({evt[g].minh,
                                       evt[g].sinh,
                                       evt[g].uinh},
                                      priv_lvl_i);
    assign cnt_we[g] = csr_we_i && cnt_rng
                     && (idx == 5'(g+3));
    assign evt_we[g] = csr_we_i && evt_rng
                     && (idx == 5'(g+3));
    assign of_vec[g] = evt[g].of;

    hpm_counter #(
      .CounterWidth (CounterWidth),
      .EvCntW       (EvCntW)
    ) u_cnt (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .inc_en    (inc_en[g]),
      .inc       (inc[g]),
      .cnt_we    (cnt_we[g]),
      .evt_we    (evt_we[g]),
      .cnt_wdata (csr_wdata_i[CounterWidth-1:0]),
      .evt_wdata (evt_wdata),
      .cnt       (cnt[g]),
      .evt       (evt[g])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcountinhibit <= '0;
      irq_q         <= 1'b0;
    end else begin
      if (csr_we_i && inh_hit) begin
        mcountinhibit <= csr_wdata_i[31:0] & InhMask;
      end
      irq_q <= |of_vec;
    end
  end

  assign lcof_irq_o = irq_q;

  always_comb begin
    csr_rdata_o = '0;
    if (inh_hit) begin
      csr_rdata_o = {32'b0, mcountinhibit};
    end
    for (int g = 0; g < int'(NrCounters); g++) begin
      if (cnt_rng && (idx == 5'(g+3))) begin
        csr_rdata_o = 64'(cnt[g]);
      end
      if (evt_rng && (idx == 5'(g+3))) begin
        csr_rdata_o = evt[g];
      end
    end
  end

endmodule

// File: doc/hpm_counter_unit.md
Name: hpm_counter_unit

Overview:
Parametrised hardware performance-monitor block: NrCounters programmable event counters (mhpmcounter3..), their event selectors (mhpmevent3..), and mcountinhibit.
- Adds privilege-mode filtering and overflow tracking with a local counter-overflow interrupt (Sscofpmf-style), which the fixed cycle/instret counters do not have.
- Sits beside the CSR register file.
- The CSR file forwards decoded accesses in the 0xB03–0xB1F, 0x323–0x33F and 0x320 ranges here and muxes back csr_rdata_o.

Parameters:
- NrCounters, 6, implemented programmable counters (1..29); counters 3..NrCounters+2 are live, the rest up to 31 are hardwired zero.
- NrEvents, 16, number of event inputs; selector value 0 = no event, 1..NrEvents-1 map to event_cnt_i entries.
- CounterWidth, 64, counter width (32..64); upper read bits are zero.
- NrCommitPorts, 2, maximum per-cycle increment per event. EvCntW = $clog2(NrCommitPorts+1).

Ports:
- clk_i, in, 1, clock.
- rst_ni, in, 1, asynchronous active-low reset.
- priv_lvl_i, in, 2, current privilege level (riscv::priv_lvl_t).
- event_cnt_i, in, NrEvents*EvCntW, per-event increment this cycle (0..NrCommitPorts).
- csr_addr_i, in, 12, CSR address.
- csr_we_i, in, 1, write strobe, full-word write already resolved by the CSR file.
- csr_wdata_i, in, 64, write data.
- csr_rdata_o, out, 64, read data, combinational.
- csr_hit_o, out, 1, csr_addr_i is in this block's address space.
- lcof_irq_o, out, 1, local counter-overflow interrupt pending.

Behaviour:
- Reset: all counters = 0, all selectors = 0, mcountinhibit = 0, all OF bits = 0, lcof_irq_o = 0.
- Combinational outputs at reset: csr_rdata_o = 0 and csr_hit_o = 0 for any address outside the ranges above.
- mhpmevent layout:
  - bit 63 = OF (sticky overflow);
  - bits 62/61/60 = MINH/SINH/UINH (inhibit counting in M/S/U);
  - bits [$clog2(NrEvents)-1:0] = event select;
  - all other bits read zero, writes to them ignored.
- mcountinhibit: bits 3..NrCounters+2 writable; other bits read zero.
- Counting: each cycle counter i adds event_cnt_i[sel_i] when all of the following hold:
  - sel_i != 0 and sel_i < NrEvents;
  - mcountinhibit[i] = 0;
  - the inhibit bit for priv_lvl_i is 0.
  - Selector values >= NrEvents count nothing.
- Width: arithmetic is CounterWidth bits, modulo 2^CounterWidth. Writes are truncated to CounterWidth bits.
- Overflow: if the increment carries out of CounterWidth, the counter wraps and OF_i is set on that clock edge. Already-set OF_i stays 1 (no re-trigger).
- lcof_irq_o: registered OR of all OF bits, valid the cycle after the wrapping edge.
  - Falls 1 cycle after the last OF is cleared.
  - OF is cleared only by software writing 0 to bit 63 of the selector.
- CSR write latency: new value visible on csr_rdata_o the cycle after csr_we_i.
- Write vs. count, same cycle on the same counter: the write wins and that cycle's increment is dropped.
- Write vs. overflow, same cycle: a selector write with OF=0 on the same cycle the counter wraps leaves OF = 1 (hardware set wins). A write with OF=1 sets it.
- Reads:
  - combinational, reflecting current register state;
  - hardwired counters/selectors (index > NrCounters+2) read 0 with csr_hit_o = 1; writes to them are ignored.
- Reset mid-count: registers clear immediately (async). Counting resumes from 0 on the first clock after rst_ni rises.

Decomposition:
- Shared package (ariane_pkg / riscv):
  - CSR address constants (CSR_MHPM_COUNTER_3, CSR_MHPM_EVENT_3, CSR_MCOUNTINHIBIT);
  - hpm_event_t packed struct (of, minh, sinh, uinh, rsvd, sel);
  - event ID constants.
- Sub-module hpm_counter: one counter + selector + OF bit, with increment enable, write port and overflow output.
- Top level holds mcountinhibit, address decode, read mux and the interrupt register.

Test Plan:
- Reset, then read 0xB03, 0x323, 0x320: rdata = 0, hit = 1. Read 0x7C0: hit = 0, rdata = 0.
- Write mhpmevent3 sel=2, drive event 2 = 1 for 10 cycles in M-mode: mhpmcounter3 = 10. Set MINH and repeat: count unchanged.
- Write mhpmcounter4 = 2^CounterWidth-2, sel=1, event 1 increment 2: counter = 0, OF4 = 1, lcof_irq_o = 1 next cycle. Write mhpmevent4 with OF=0: irq drops 1 cycle later.
- Same-cycle write of 0x100 to mhpmcounter3 while its event fires with increment 2: read back 0x100 exactly.
- Set mcountinhibit bit 5: counter 5 frozen while counter 3 on the same event keeps counting. Write 0xFFFF_FFFF to mcountinhibit: reads back only bits 3..NrCounters+2.
- NrCounters=6: write 0xB10 = 5, read back 0, hit = 1. With CounterWidth=32: write 0x1_0000_0005 to 0xB03, read 0x5.
